// File: rtl/vector_exec_sequencer.sv
// Chunk sequencer for the vector execute stage: walks a V-element operation
// through the L-lane ALU array one chunk per cycle and reports completion.
module vector_exec_sequencer #(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 4,
  localparam int CHUNKS = (V + L - 1) / L,
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start_i,
  input  logic [1:0]    OpType_i,
  input  logic [1:0]    ALUControl_i,
  input  logic          stall_i,
  output logic [CW-1:0] counter_o,
  output logic [1:0]    OpType_o,
  output logic [1:0]    ALUControl_o,
  output logic          chunk_valid_o,
  output logic          join_we_o,
  output logic [L-1:0]  lane_mask_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    fsm_state
);

  if (N < 1 || V < 1 || L < 1) begin : g_param_check
    $error("vector_exec_sequencer: N, V and L must be positive");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]    OP_SCALAR   = 2'b00;
  localparam logic [1:0]    OP_RESERVED = 2'b11;
  localparam logic [CW-1:0] LAST_CHUNK  = CW'(CHUNKS - 1);

  state_t        state, next_state;
  logic [CW-1:0] counter_q, counter_d;
  logic [CW-1:0] last_idx_q, last_idx_d;
  logic [1:0]    op_type_q, alu_ctrl_q;
  logic          done_q, err_q, busy_q;
  logic          accept, reject, chunk_go;

  always_comb begin
    next_state = state;
    counter_d  = counter_q;
    last_idx_d = last_idx_q;
    accept     = 1'b0;
    reject     = 1'b0;
    chunk_go   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (OpType_i == OP_RESERVED) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = RUN;
            counter_d  = '0;
            last_idx_d = (OpType_i == OP_SCALAR) ? '0 : LAST_CHUNK;
          end
        end
      end
      RUN: begin
        // A stalled chunk is neither presented nor joined; everything holds.
        if (!stall_i) begin
          chunk_go = 1'b1;
          if (counter_q == last_idx_q) begin
            next_state = DONE;
          end else begin
            counter_d = counter_q + CW'(1);
          end
        end
      end
      DONE: begin
        next_state = IDLE;
        counter_d  = '0;
      end
      default: begin
        next_state = IDLE;
        counter_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      counter_q  <= '0;
      last_idx_q <= '0;
      op_type_q  <= 2'b00;
      alu_ctrl_q <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= next_state;
      counter_q  <= counter_d;
      last_idx_q <= last_idx_d;
      if (accept) begin
        op_type_q  <= OpType_i;
        alu_ctrl_q <= ALUControl_i;
      end
      done_q <= (next_state == DONE);
      err_q  <= reject;
      busy_q <= (next_state != IDLE);
    end
  end

  // Lanes past the end of the vector are masked off in the final chunk.
  always_comb begin
    lane_mask_o = '0;
    if (state == RUN) begin
      if (op_type_q == OP_SCALAR) begin
        lane_mask_o = L'(1);
      end else begin
        for (int l = 0; l < L; l++) begin
          lane_mask_o[l] = ((int'(counter_q) * L + l) < V);
        end
      end
    end
  end

  assign chunk_valid_o = chunk_go;
  assign join_we_o     = chunk_go;
  assign counter_o     = counter_q;
  assign OpType_o      = op_type_q;
  assign ALUControl_o  = alu_ctrl_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign fsm_state     = state;

endmodule

// File: doc/vector_exec_sequencer.md
# vector_exec_sequencer

Control block for the vector execute stage: sequences a V-element vector operation through the L-lane ALU array one chunk of L elements per cycle. It drives the shared chunk counter consumed by ForkVector and JoinVector, latches the operation configuration for the four vector ALUs, and raises a one-cycle completion pulse to the pipeline. Scalar operations take a single pass through lane 0 only.

## Interface
- N, 32, element width in bits (configuration only; no data passes through this block)
- V, 20, elements per vector register
- L, 4, parallel ALU lanes
- CHUNKS, derived, ceil(V/L) (5 at defaults)
- CW, derived, max(1, $clog2(CHUNKS)), counter width

Ports:
- CLK  in  1  clock; single clock domain
- RST  in  1  synchronous, active-high reset
- start_i  in  1  request a new operation; sampled only in IDLE
- OpType_i  in  2  00 scalar, 01 vector-vector, 10 vector-scalar, 11 reserved
- ALUControl_i  in  2  ALU function for the operation
- stall_i  in  1  hold the current chunk; the counter does not advance
- counter_o  out  CW  chunk index for ForkVector/JoinVector
- OpType_o  out  2  latched OpType for ForkVector
- ALUControl_o  out  2  latched ALU function for all lanes
- chunk_valid_o  out  1  the current chunk is presented to the ALUs this cycle
- join_we_o  out  1  JoinVector captures the lane results this cycle
- lane_mask_o  out  L  per-lane valid bits for the current chunk
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse: reserved OpType rejected

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN: start_i=1 and OpType_i≠11.
  - Latch OpType_i and ALUControl_i.
  - counter_o is cleared to 0.
  - last_idx is set to 0 for scalar operations, CHUNKS-1 otherwise.
- IDLE with start_i=1 and OpType_i=11: pulse err_o for one cycle, stay in IDLE, latch nothing.
- start_i is ignored in RUN and DONE (no queueing).
- RUN with stall_i=0:
  - chunk_valid_o=1, join_we_o=1.
  - If counter_o==last_idx, go to DONE and hold counter_o; otherwise counter_o increments by 1.
- RUN with stall_i=1: chunk_valid_o=0, join_we_o=0, counter_o and state held.
- DONE: done_o=1 for exactly one cycle, then return to IDLE. counter_o returns to 0 on that transition. stall_i has no effect in DONE.
- lane_mask_o:
  - Bit l is 1 iff counter_o*L+l < V, evaluated combinationally from counter_o.
  - Scalar operation: lane_mask_o = 1 (lane 0 only).
  - Outside RUN: lane_mask_o = 0.
- busy_o is 1 in RUN and DONE.
- OpType_o and ALUControl_o hold their latched values until the next accepted start.
- The counter never exceeds last_idx and never wraps.
- RST at any time: state IDLE; no done_o or err_o pulse for the aborted operation.

## Timing
- Reset values: counter_o=0, OpType_o=00, ALUControl_o=00, chunk_valid_o=0, join_we_o=0, lane_mask_o=0, busy_o=0, done_o=0, err_o=0.
- All outputs are registered except lane_mask_o, chunk_valid_o and join_we_o. These three are combinational from state, counter and stall_i. The ALUs are combinational, so the join write happens in the same cycle the chunk is presented.
- Vector operation with start accepted at edge t (no stalls):
  - Chunks 0..CHUNKS-1 occupy cycles t+1..t+CHUNKS.
  - done_o is high in cycle t+CHUNKS+1.
  - The next start can be accepted at the edge ending cycle t+CHUNKS+2.
- Each stall cycle adds exactly one cycle of latency.
- Scalar operation: one RUN cycle, then done_o, so done_o is high in cycle t+2.
- err_o is high in cycle t+1 when a reserved OpType is rejected at edge t.

## Test plan
- Reset, then vector-vector start with ALUControl_i=10 (V=20, L=4):
  - counter_o steps 0,1,2,3,4 in cycles 1–5.
  - join_we_o is high in all five cycles; lane_mask_o=1111 throughout.
  - done_o is high in cycle 6 only; ALUControl_o=10.
- V=18 instance:
  - lane_mask_o=1111 for chunks 0–3 and 0011 for chunk 4.
  - done_o arrives after 5 chunks.
- Stall handling: stall_i high during chunk 2 for 3 cycles.
  - counter_o holds at 2 and join_we_o=0 for those cycles.
  - done_o is high in cycle 9.
- Scalar start (OpType_i=00):
  - One cycle with counter_o=0, lane_mask_o=0001.
  - done_o in the next cycle.
  - A start_i pulse during DONE is ignored.
- OpType_i=11 start:
  - err_o pulses once; busy_o stays 0.
  - OpType_o keeps its previously latched value.
- RST asserted at chunk 3:
  - All outputs return to their reset values the next cycle, with no done_o.
  - A new start is accepted immediately after reset.
